// File: rtl/ram_pkg.sv
// Shared defaults for the single-port RAM slice.
// DEPTH is derived from the address width. Instances may override it
// with a smaller value, which leaves part of the address space unused.
package ram_pkg;

    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 6;

    // Number of words that an address of the given width can reach.
    function automatic int ram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int RAM_DEPTH = ram_depth(RAM_ADDR_WIDTH);

endpackage

// File: rtl/spram_core.sv
// spram_core: the storage array and its synchronous write port.
// The read port is asynchronous. The parent registers it, so the whole
// path still maps onto a synchronous-read block RAM.
//   clk    : write clock
//   wr_en  : write strobe, already qualified by the parent
//   addr   : shared read/write address
//   wdata  : write data
//   rdata  : mem[addr], combinational
module spram_core
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DEPTH      = ram_depth(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    // The array has no reset, so contents survive rst_n.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/single_port_ram.sv
// single_port_ram: single-port RAM with a write-first, 1-cycle
// registered read.
//   clk          : sole clock, rising edge
//   rst_n        : async active-low; clears data_out only and blocks writes
//   data_in      : write data
//   ram_address  : shared read/write address
//   write_enable : 1 = write cycle, 0 = read cycle
//   data_out     : registered read data (the new data on a write)
module single_port_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DEPTH      = ram_depth(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] ram_address,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Compare with one extra bit so DEPTH == 2**ADDR_WIDTH fits.
    // In that case the check is always true.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  in_range;
    logic                  core_we;
    logic [DATA_WIDTH-1:0] rd_data;

    assign in_range = ({1'b0, ram_address} < DEPTH_LIM);

    // rst_n gates the strobe. If reset is low at the edge, the word is
    // left untouched. Otherwise it is fully written. A partial write
    // cannot happen.
    assign core_we = write_enable & in_range & rst_n;

    spram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk   (clk),
        .wr_en (core_we),
        .addr  (ram_address),
        .wdata (data_in),
        .rdata (rd_data)
    );

    // Write-first output register. Out-of-range addresses read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            data_out <= '0;
        else if (!in_range)    data_out <= '0;
        else if (write_enable) data_out <= data_in;
        else                   data_out <= rd_data;
    end

endmodule

// File: tb/tb_single_port_ram.sv
module tb_single_port_ram;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic [5:0] ram_address;
    logic       write_enable;
    logic [7:0] data_out;
    logic [7:0] data_out_s;   // DEPTH=48 instance, same stimulus

    int n_chk  = 0;
    int n_fail = 0;

    single_port_ram u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .ram_address  (ram_address),
        .write_enable (write_enable),
        .data_out     (data_out)
    );

    single_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(48)) u_dut_s (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .ram_address  (ram_address),
        .write_enable (write_enable),
        .data_out     (data_out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample on the next falling edge.
    task automatic cyc(input logic we, input logic [5:0] a, input logic [7:0] d);
        write_enable = we;
        ram_address  = a;
        data_in      = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // write / read-back / isolation / boundary / write-first
        vecs[0]  = '{1'b1, 6'd0,  8'h10, 8'h10};
        vecs[1]  = '{1'b1, 6'd2,  8'h11, 8'h11};
        vecs[2]  = '{1'b1, 6'd7,  8'hAF, 8'hAF};
        vecs[3]  = '{1'b0, 6'd0,  8'h00, 8'h10};
        vecs[4]  = '{1'b0, 6'd2,  8'h00, 8'h11};
        vecs[5]  = '{1'b0, 6'd7,  8'h00, 8'hAF};
        vecs[6]  = '{1'b1, 6'd2,  8'h55, 8'h55};
        vecs[7]  = '{1'b0, 6'd0,  8'h00, 8'h10};
        vecs[8]  = '{1'b0, 6'd7,  8'h00, 8'hAF};
        vecs[9]  = '{1'b0, 6'd2,  8'h00, 8'h55};
        vecs[10] = '{1'b1, 6'd63, 8'hFF, 8'hFF};
        vecs[11] = '{1'b1, 6'd0,  8'h01, 8'h01};
        vecs[12] = '{1'b0, 6'd63, 8'h00, 8'hFF};
        vecs[13] = '{1'b0, 6'd0,  8'h00, 8'h01};
        vecs[14] = '{1'b1, 6'd5,  8'h20, 8'h20};
        vecs[15] = '{1'b1, 6'd5,  8'h3C, 8'h3C};
        vecs[16] = '{1'b0, 6'd5,  8'h00, 8'h3C};

        rst_n = 1'b0; write_enable = 1'b0; ram_address = '0; data_in = '0;
        #1;
        check("reset_state", data_out, 8'h00);
        check("reset_state_s", data_out_s, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].we, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d", i), data_out, vecs[i].exp);
        end

        // Reset pulsed mid-cycle during a write: data_out clears immediately,
        // the write to addr 2 is blocked, and memory is retained.
        write_enable = 1'b1; ram_address = 6'd2; data_in = 8'hEE;
        #2 rst_n = 1'b0;
        #1 check("reset_async_clear", data_out, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", data_out, 8'h00);
        rst_n = 1'b1;
        cyc(1'b0, 6'd7, 8'h00);
        check("reset_retain_7", data_out, 8'hAF);
        cyc(1'b0, 6'd2, 8'h00);
        check("reset_blocked_write", data_out, 8'h55);

        // Out-of-range handling on the DEPTH=48 instance.
        cyc(1'b0, 6'd63, 8'h00);
        check("oor_read_63_s", data_out_s, 8'h00);
        check("full_read_63", data_out, 8'hFF);
        cyc(1'b1, 6'd50, 8'h77);
        cyc(1'b0, 6'd50, 8'h00);
        check("oor_read_50_s", data_out_s, 8'h00);
        check("full_read_50", data_out, 8'h77);
        cyc(1'b1, 6'd47, 8'hEE);
        check("last_word_write_s", data_out_s, 8'hEE);
        cyc(1'b0, 6'd0, 8'h00);
        check("in_range_read_0_s", data_out_s, 8'h01);
        cyc(1'b0, 6'd47, 8'h00);
        check("last_word_read_s", data_out_s, 8'hEE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/single_port_ram.md
SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6, address width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_WIDTH (64), number of words.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data_in  input  DATA_WIDTH  write data.
REQ-007 ram_address  input  ADDR_WIDTH  shared read/write address.
REQ-008 write_enable  input  1  high = write cycle; low = read cycle.
REQ-009 data_out  output  DATA_WIDTH  registered read data.
REQ-010 The design SHALL use one clock, with reset asynchronous and active-low.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_WIDTH bits, all sharing a single address port.
REQ-012 On a rising edge with write_enable=1, the block SHALL write data_in to mem[ram_address].
REQ-013 data_out SHALL be registered and update on every rising edge; read latency is 1 cycle.
REQ-014 On a read cycle (write_enable=0), data_out SHALL become mem[ram_address] after the edge.
REQ-015 On a write cycle, data_out SHALL become the new data_in (write-first), not the old contents.
REQ-016 Only the addressed word SHALL change on a write; all other words SHALL hold their values.
REQ-017 Back-to-back writes and reads to any addresses SHALL be supported every cycle, with no stall and no handshake.
REQ-018 Address decode: every value 0..DEPTH-1 SHALL be valid; no wrap or aliasing is required when DEPTH = 2**ADDR_WIDTH.
REQ-019 If DEPTH < 2**ADDR_WIDTH, writes to out-of-range addresses SHALL be ignored, and reads from them SHALL return 0.
REQ-020 Reading a word that has never been written SHALL return an undefined value; benches SHALL NOT check it.
REQ-021 An X or Z on write_enable SHALL NOT corrupt memory in synthesis; simulation MAY propagate X.

Reset
REQ-022 rst_n=0 SHALL clear data_out to 0 immediately, with no clock required.
REQ-023 Reset SHALL NOT clear the memory array; contents SHALL persist across reset, which permits block-RAM inference.
REQ-024 While rst_n=0, writes SHALL be blocked.
REQ-025 The first edge after rst_n rises SHALL operate normally.
REQ-026 A reset asserted during a write cycle SHALL leave the targeted word either unchanged or fully written; a partial write is not permitted.

Structure
REQ-027 A shared package (ram_pkg) SHALL hold the DATA_WIDTH/ADDR_WIDTH defaults and the derived DEPTH.
REQ-028 The memory array plus write port SHALL be one sub-module, spram_core; the top level SHALL add the output register, the reset logic and the range check.
REQ-029 The memory SHALL be coded as an inferable synchronous-write array, with no vendor primitives.

Verification
REQ-030 Write test: write_enable=1, with 0x10@0, 0x11@2, 0xAF@7 on consecutive edges -> data_out = 0x10, 0x11, 0xAF one cycle after each write.
REQ-031 Read-back test: write_enable=0, addresses 0, 2, 7 on consecutive edges -> data_out = 0x10, 0x11, 0xAF, each one cycle later.
REQ-032 Isolation test: write 0x55@2, then read addresses 0 and 7 -> 0x10 and 0xAF (unchanged), and address 2 -> 0x55.
REQ-033 Reset test: pulse rst_n low mid-cycle -> data_out = 0x00 immediately; a subsequent read of address 7 returns 0xAF (memory retained).
REQ-034 Boundary test: write 0xFF@63 and 0x01@0, then read address 63 then address 0 -> 0xFF, 0x01.
REQ-035 Write-first test: write 0x3C@5 -> data_out = 0x3C on the next cycle, even though address 5 previously held a different value.
